cpu_trace_buf: RTL

//  Trace capture buffer directly downstream of the CPU tracer. Accepts one 256-bit

---
 rtl/cpu_trace_buf.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cpu_trace_buf.sv
// Circular trace capture buffer: 256-bit packets in, 32-bit words out over valid/ready.
// Optional privilege filter enabled by defining CPU_TRACE_FILTER_EN (adds prv_mask input).
module cpu_trace_buf #(
    parameter int DEPTH     = 16,
    parameter int POST_PKTS = 4,
    parameter int OVF_W     = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     trace_en,
    input  logic                     wrap_mode,
    input  logic                     trig_on_trap,
    input  logic                     clr,
`ifdef CPU_TRACE_FILTER_EN
    input  logic [3:0]               prv_mask,
`endif
    input  logic                     pkg_valid,
    input  logic [255:0]             pkg,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     frozen,
    output logic [OVF_W-1:0]         ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(POST_PKTS + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [PW-1:0] POST_INIT = PW'(POST_PKTS);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   post_cnt;
    logic [255:0]    mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [2:0]      wcnt;
    logic            cap_en, eligible, beat, pop, wr, ovr, ovf;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!trace_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARMED;
                ARMED:   if (wr && trig_on_trap && pkg[255]) state_nxt = POST;
                POST:    if (wr && post_cnt == PW'(1)) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        cap_en = trace_en && (state == ARMED || state == POST);
        frozen = (state == DONE);
    end

    // The trap packet arms the window; only packets after it decrement the count.
    always_ff @(posedge clk) begin
        if (srst)                                post_cnt <= '0;
        else if (state == ARMED && state_nxt == POST) post_cnt <= POST_INIT;
        else if (state == POST && wr)            post_cnt <= post_cnt - 1'b1;
    end

`ifdef CPU_TRACE_FILTER_EN
    assign eligible = pkg_valid && prv_mask[pkg[254:253]];
`else
    assign eligible = pkg_valid;
`endif

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign out_valid = !empty;
    assign beat      = out_valid && out_ready;
    assign pop       = beat && (wcnt == 3'd7);

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    always_comb begin
        wr  = 1'b0;
        ovr = 1'b0;
        ovf = 1'b0;
        if (cap_en && eligible && !clr) begin
            if (!full || pop) begin
                wr = 1'b1;
            end else if (wrap_mode && wcnt == 3'd0) begin
                wr  = 1'b1;
                ovr = 1'b1;
                ovf = 1'b1;
            end else begin
                ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            wptr    <= '0;
            rptr    <= '0;
            wcnt    <= '0;
            count   <= '0;
            ovf_cnt <= '0;
        end else begin
            if (wr)         wptr <= wptr + 1'b1;
            if (pop || ovr) rptr <= rptr + 1'b1;
            if (beat)       wcnt <= wcnt + 1'b1;
            if (wr && !ovr && !pop)  count <= count + 1'b1;
            else if (pop && !wr)     count <= count - 1'b1;
            if (ovf)        ovf_cnt <= sat_inc(ovf_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= pkg;
    end

    assign out_data = empty ? 32'd0 : mem[rptr][{wcnt, 5'b00000} +: 32];
    assign out_last = !empty && (wcnt == 3'd7);

endmodule
